// File: rtl/morse_pkg.sv
// Shared Morse definitions for the letter encoder/decoder pair.
// Contents: letter codes A..H (match the encoder's SW[2:0] encoding),
// symbol encoding, half-unit thresholds, decoder state enum and the
// (nsym, sym) -> {hit, code} lookup used when a letter is closed.
package morse_pkg;

    localparam logic [2:0] LETTER_A = 3'd0;
    localparam logic [2:0] LETTER_B = 3'd1;
    localparam logic [2:0] LETTER_C = 3'd2;
    localparam logic [2:0] LETTER_D = 3'd3;
    localparam logic [2:0] LETTER_E = 3'd4;
    localparam logic [2:0] LETTER_F = 3'd5;
    localparam logic [2:0] LETTER_G = 3'd6;
    localparam logic [2:0] LETTER_H = 3'd7;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    // Thresholds in half-units (one half-unit = TICK_DIV/2 clocks).
    localparam logic [3:0] DOT_MAX_H  = 4'd3;
    localparam logic [3:0] DASH_MAX_H = 4'd8;
    localparam logic [3:0] GAP_H      = 4'd4;
    localparam logic [3:0] HCNT_MAX   = 4'd15;
    localparam logic [2:0] MAX_SYM    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_EMIT  = 2'd3
    } morse_state_e;

    // Returns {hit, code}. The first keyed symbol sits in the highest
    // used bit of sym, so only sym[nsym-1:0] is significant.
    function automatic logic [3:0] lookup_letter(input logic [2:0] nsym,
                                                 input logic [3:0] sym);
        logic [3:0] res;
        res = 4'b0000;
        case (nsym)
            3'd1: begin
                if (sym[0] == SYM_DOT) res = {1'b1, LETTER_E};
                else                   res = 4'b0000;
            end
            3'd2: begin
                if (sym[1:0] == 2'b01) res = {1'b1, LETTER_A};
                else                   res = 4'b0000;
            end
            3'd3: begin
                case (sym[2:0])
                    3'b100:  res = {1'b1, LETTER_D};
                    3'b110:  res = {1'b1, LETTER_G};
                    default: res = 4'b0000;
                endcase
            end
            3'd4: begin
                case (sym)
                    4'b1000: res = {1'b1, LETTER_B};
                    4'b1010: res = {1'b1, LETTER_C};
                    4'b0010: res = {1'b1, LETTER_F};
                    4'b0000: res = {1'b1, LETTER_H};
                    default: res = 4'b0000;
                endcase
            end
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/morse_letter_decoder_if.sv
// Keyed-line input and decoded-letter outputs of the Morse letter decoder.
//   morse_in      keyed line, 1 = mark (asynchronous to the clock)
//   letter        decoded letter code, held until the next valid
//   letter_valid  one-cycle pulse, letter updated
//   letter_err    one-cycle pulse, malformed/unknown letter
//   busy          decoder is inside a letter
// master drives the line (encoder / bench), slave is the decoder.
interface morse_letter_decoder_if;
    logic       morse_in;
    logic [2:0] letter;
    logic       letter_valid;
    logic       letter_err;
    logic       busy;

    modport master (output morse_in, input letter, letter_valid, letter_err, busy);
    modport slave  (input morse_in, output letter, letter_valid, letter_err, busy);
endinterface

// File: rtl/morse_tick_gen.sv
// Half-unit tick generator.
//   clk    system clock
//   reset  synchronous, active-high
//   clr    restart the half-unit from zero (line edge)
//   tick   high on the cycle the divider wraps
// tick does not depend on clr, so a half-unit that completes on the same
// cycle as an edge is still reported.
module morse_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int HALF = TICK_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] ZERO = CW'(0);

    logic [CW-1:0] cnt_r;

    // Divider counting 0..HALF-1, restarted by clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= ZERO;
        end else if (clr) begin
            cnt_r <= ZERO;
        end else if (cnt_r == LAST) begin
            cnt_r <= ZERO;
        end else begin
            cnt_r <= cnt_r + ONE;
        end
    end

    assign tick = (cnt_r == LAST);
endmodule

// File: rtl/morse_letter_decoder.sv
// Morse letter decoder: measures mark/space durations of a keyed line in
// half-units and recovers letters A..H as 3-bit codes.
//   CLOCK_50  system clock (rising edge)
//   reset     synchronous, active-high
//   bus       slave side of morse_letter_decoder_if (morse_in in;
//             letter, letter_valid, letter_err, busy out, all registered)
module morse_letter_decoder
    import morse_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    morse_letter_decoder_if.slave        bus
);
    logic         sync1_r, sync2_r, prev_r;
    logic         rise_s, fall_s, edge_s, tick_s;
    logic [3:0]   hcnt_r, hmeas_s;
    morse_state_e state_r, state_n;
    logic [3:0]   sym_r, sym_n;
    logic [2:0]   nsym_r, nsym_n;
    logic         errf_r, errf_n;
    logic [2:0]   letter_r, letter_n;
    logic         valid_r, valid_n, lerr_r, lerr_n, busy_r;
    logic [3:0]   hit_code_s;

    // Two-flop synchronizer plus previous-value flop for edge detection.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= bus.morse_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign rise_s = sync2_r & ~prev_r;
    assign fall_s = ~sync2_r & prev_r;
    assign edge_s = rise_s | fall_s;

    morse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (CLOCK_50),
        .reset (reset),
        .clr   (edge_s),
        .tick  (tick_s)
    );

    // Half-unit count since the last edge, saturating.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hcnt_r <= 4'd0;
        end else if (edge_s) begin
            hcnt_r <= 4'd0;
        end else if (tick_s && (hcnt_r != HCNT_MAX)) begin
            hcnt_r <= hcnt_r + 4'd1;
        end
    end

    // Duration including a half-unit that completes this very cycle, so a
    // W-cycle interval measures exactly floor(W / half-unit).
    always_comb begin
        if (tick_s && (hcnt_r != HCNT_MAX)) begin
            hmeas_s = hcnt_r + 4'd1;
        end else begin
            hmeas_s = hcnt_r;
        end
    end

    assign hit_code_s = lookup_letter(nsym_r, sym_r);

    // Next-state, symbol store and result logic.
    always_comb begin
        state_n  = state_r;
        sym_n    = sym_r;
        nsym_n   = nsym_r;
        errf_n   = errf_r;
        letter_n = letter_r;
        valid_n  = 1'b0;
        lerr_n   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // prev_r catches a rise that arrived while in EMIT.
                if (rise_s || prev_r) begin
                    sym_n  = 4'd0;
                    nsym_n = 3'd0;
                    if (fall_s) begin
                        // Missed mark already ended: only a glitch fits here.
                        errf_n  = 1'b1;
                        state_n = ST_SPACE;
                    end else begin
                        errf_n  = 1'b0;
                        state_n = ST_MARK;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MARK: begin
                if (fall_s) begin
                    state_n = ST_SPACE;
                    if ((hmeas_s == 4'd0) || (hmeas_s > DASH_MAX_H)) begin
                        errf_n = 1'b1;
                    end else if (nsym_r == MAX_SYM) begin
                        errf_n = 1'b1;
                    end else begin
                        sym_n  = {sym_r[2:0], (hmeas_s > DOT_MAX_H) ? SYM_DASH : SYM_DOT};
                        nsym_n = nsym_r + 3'd1;
                    end
                end else begin
                    state_n = ST_MARK;
                end
            end
            ST_SPACE: begin
                // Closing the letter wins over a rise on the same cycle.
                if (tick_s && (hmeas_s == GAP_H)) begin
                    state_n = ST_EMIT;
                end else if (rise_s) begin
                    state_n = ST_MARK;
                end else begin
                    state_n = ST_SPACE;
                end
            end
            ST_EMIT: begin
                state_n = ST_IDLE;
                if (!errf_r && hit_code_s[3]) begin
                    valid_n  = 1'b1;
                    letter_n = hit_code_s[2:0];
                end else begin
                    lerr_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, symbol store and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            sym_r    <= 4'd0;
            nsym_r   <= 3'd0;
            errf_r   <= 1'b0;
            letter_r <= 3'd0;
            valid_r  <= 1'b0;
            lerr_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            sym_r    <= sym_n;
            nsym_r   <= nsym_n;
            errf_r   <= errf_n;
            letter_r <= letter_n;
            valid_r  <= valid_n;
            lerr_r   <= lerr_n;
            busy_r   <= (state_n != ST_IDLE);
        end
    end

    assign bus.letter       = letter_r;
    assign bus.letter_valid = valid_r;
    assign bus.letter_err   = lerr_r;
    assign bus.busy         = busy_r;
endmodule

// File: tb/tb_morse_letter_decoder.sv
// Scoreboard bench for morse_letter_decoder (TICK_DIV = 8, unit = 8 cycles).
module tb_morse_letter_decoder;
    localparam int TICK_DIV = 8;
    localparam int HALF     = TICK_DIV / 2;
    localparam int LAT      = 2 * TICK_DIV + 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    morse_letter_decoder_if bus_if ();

    morse_letter_decoder #(.TICK_DIV(TICK_DIV)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus_if)
    );

    typedef struct {
        bit         is_err;
        logic [2:0] code;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         errors   = 0;
    int         checks   = 0;
    int         cyc      = 0;
    int         fall_cyc = 0;
    logic [2:0] held_letter = 3'd0;
    int         code_of[string];
    string      pat[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: durations -> half-units -> dot/dash string -> table.
    function automatic void push_expect(input int marks[$]);
        string s;
        bit    bad;
        exp_t  e;
        int    h;
        s   = "";
        bad = 1'b0;
        foreach (marks[i]) begin
            h = marks[i] / HALF;
            if (h < 1 || h > 8) bad = 1'b1;
            else if (h <= 3)    s = {s, "."};
            else                s = {s, "-"};
        end
        if (s.len() > 4) bad = 1'b1;
        if (!bad && code_of.exists(s)) begin
            e.is_err    = 1'b0;
            e.code      = 3'(code_of[s]);
            held_letter = e.code;
        end else begin
            e.is_err = 1'b1;
            e.code   = held_letter;
        end
        e.cyc = fall_cyc;
        exp_q.push_back(e);
    endfunction

    // Drive a level for n cycles; entered and left just after a rising edge.
    task automatic hold(input logic v, input int n);
        bus_if.morse_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_marks(input int marks[$], input int gap_lo, input int gap_hi, input int tail);
        foreach (marks[i]) begin
            hold(1'b1, marks[i]);
            if (i == marks.size() - 1) begin
                fall_cyc = cyc;
                push_expect(marks);
                hold(1'b0, tail);
            end else begin
                hold(1'b0, $urandom_range(gap_hi, gap_lo));
            end
        end
    endtask

    task automatic send_pattern(input string p, input int dot_w, input int dash_w,
                                input int gap, input int tail);
        int m[$];
        for (int i = 0; i < p.len(); i++) begin
            if (p[i] == "-") m.push_back(dash_w);
            else             m.push_back(dot_w);
        end
        send_marks(m, gap, gap, tail);
    endtask

    // Monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset == 1'b0 && (bus_if.letter_valid === 1'b1 || bus_if.letter_err === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%b err=%b letter=%0d at cycle %0d, nothing expected",
                         bus_if.letter_valid, bus_if.letter_err, bus_if.letter, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_err",   {31'd0, bus_if.letter_err},   {31'd0, e.is_err});
                check("pulse_valid", {31'd0, bus_if.letter_valid}, {31'd0, ~e.is_err});
                check("letter",      {29'd0, bus_if.letter},       {29'd0, e.code});
                check("pulse_cycle", cyc, e.cyc + LAT);
            end
        end
    end

    initial begin
        int m[$];
        pat[0] = ".-";   pat[1] = "-...";  pat[2] = "-.-.";  pat[3] = "-..";
        pat[4] = ".";    pat[5] = "..-.";  pat[6] = "--.";   pat[7] = "....";
        for (int i = 0; i < 8; i++) code_of[pat[i]] = i;

        bus_if.morse_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_letter", {29'd0, bus_if.letter}, 32'd0);
        check("reset_valid",  {31'd0, bus_if.letter_valid}, 32'd0);
        check("reset_err",    {31'd0, bus_if.letter_err}, 32'd0);
        check("reset_busy",   {31'd0, bus_if.busy}, 32'd0);
        reset = 1'b0;
        hold(1'b0, 20);

        // Every letter with nominal encoder timing.
        for (int l = 0; l < 8; l++) send_pattern(pat[l], 8, 24, 8, 30);
        check("idle_busy", {31'd0, bus_if.busy}, 32'd0);

        // Threshold boundaries.
        send_pattern(".",  12, 24, 8, 30);
        send_pattern(".-", 8, 16, 8, 30);
        send_pattern("-",  8, 36, 8, 30);
        send_pattern(".-", 8, 24, 15, 30);
        send_pattern(".",  8, 24, 8, 16);
        send_pattern("-",  8, 24, 8, 30);

        // Pattern errors.
        send_pattern("....", 8, 24, 8, 30);
        send_pattern(".....", 8, 24, 8, 30);
        send_pattern("--", 8, 24, 8, 30);
        send_pattern(".", 2, 24, 8, 30);

        // Back-to-back letters with the minimum closing gap.
        send_pattern(".-",  8, 24, 8, 16);
        send_pattern("--.", 8, 24, 8, 30);

        // Stuck-high line.
        bus_if.morse_in = 1'b1;
        hold(1'b1, 250);
        check("stuck_busy_mid", {31'd0, bus_if.busy}, 32'd1);
        hold(1'b1, 250);
        check("stuck_busy_end", {31'd0, bus_if.busy}, 32'd1);
        fall_cyc = cyc;
        m = {500};
        push_expect(m);
        hold(1'b0, 30);

        // Reset in the middle of a dash after a non-zero letter.
        send_pattern("....", 8, 24, 8, 30);
        hold(1'b1, 10);
        reset = 1'b1;
        bus_if.morse_in = 1'b0;
        @(posedge clk);
        #1;
        held_letter = 3'd0;
        check("midreset_busy",   {31'd0, bus_if.busy}, 32'd0);
        check("midreset_letter", {29'd0, bus_if.letter}, 32'd0);
        check("midreset_valid",  {31'd0, bus_if.letter_valid}, 32'd0);
        check("midreset_err",    {31'd0, bus_if.letter_err}, 32'd0);
        hold(1'b0, 2);
        reset = 1'b0;
        hold(1'b0, 10);
        send_pattern(".", 8, 24, 8, 30);

        // Randomized letters, with some arbitrary-width mark sequences.
        for (int n = 0; n < 40; n++) begin
            m = {};
            if ($urandom_range(4, 0) == 0) begin
                for (int k = 0; k < int'($urandom_range(6, 1)); k++) m.push_back($urandom_range(40, 2));
            end else begin
                string p;
                p = pat[$urandom_range(7, 0)];
                for (int k = 0; k < p.len(); k++) begin
                    if (p[k] == "-") m.push_back($urandom_range(35, 16));
                    else             m.push_back($urandom_range(15, 4));
                end
            end
            send_marks(m, 4, 15, $urandom_range(30, 16));
        end

        // Drain outstanding expectations within a bounded time.
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/morse_letter_decoder.md
# morse_letter_decoder

Receives a Morse-keyed on/off line (the LEDR[0]-style lamp drive produced by the Lab 5 Part 4 Morse encoder), measures mark and space durations against a half-second time unit, and recovers letters A–H as 3-bit codes matching the encoder's SW[2:0] encoding. Sits directly downstream of the encoder, so a loopback on the board checks encoder output end to end. Results go to LEDs/HEX through a one-cycle valid pulse.

## Interface
- TICK_DIV, 25_000_000: CLOCK_50 cycles per Morse unit (0.5 s). Must be even and ≥4. Benches use 8.
- CLOCK_50  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- morse_in  input  1  keyed line, 1 = mark (lamp on); asynchronous to CLOCK_50.
- letter  output  3  decoded letter: A=000, B=001, C=010, D=011, E=100, F=101, G=110, H=111; held until next valid.
- letter_valid  output  1  one-cycle pulse, letter updated this cycle.
- letter_err  output  1  one-cycle pulse, malformed or unknown letter; letter unchanged.
- busy  output  1  high while state ≠ IDLE.

## Operation
- morse_in passes through a 2-flop synchronizer; a third flop gives the previous value for edge detection (rise/fall).
- Half-unit tick: divider counts 0..TICK_DIV/2−1 and ticks on wrap. It clears to 0 on every detected edge, so durations are measured from the edge.
- hcnt: 4-bit half-unit count, saturates at 15, clears on every edge.
- Symbol store: sym[3:0] shifts left, new symbol into bit 0 (dot=0, dash=1). Count nsym is 3 bits. err_f is a sticky flag.
- States:
  - IDLE: on rise → MARK; clear sym, nsym, err_f.
  - MARK: on fall, classify hcnt. 0 → set err_f (glitch). 1–3 → dot. 4–8 → dash. ≥9 → set err_f. If a valid symbol arrives with nsym=4, set err_f (5th symbol). Otherwise shift it in and nsym++. Then → SPACE.
  - SPACE: a rise before hcnt reaches 4 → MARK. When hcnt reaches 4 (2 units of silence) → EMIT.
  - EMIT, one cycle: if err_f=0 and (nsym, sym) matches the table, pulse letter_valid and load letter; otherwise pulse letter_err. → IDLE.
- Match table, (nsym, sym[nsym−1:0]): A (2,01), B (4,1000), C (4,1010), D (3,100), E (1,0), F (4,0010), G (3,110), H (4,0000).
- A rise while in EMIT is not lost: IDLE sees the held level through the edge flop one cycle later, and the rise is treated as a new mark with hcnt counted from that edge.
- A line held high indefinitely keeps the block in MARK with hcnt saturated. No output until the line falls and 2 units of silence follow, then letter_err.

## Timing
- Reset, including mid-letter: letter=000, letter_valid=0, letter_err=0, busy=0, state IDLE, divider/hcnt/sym/nsym/err_f cleared, synchronizer flops cleared. Takes effect on the first edge with reset high.
- Edge detection latency: 3 cycles from a morse_in change to the rise/fall strobe. The latency is the same for both edges, so measured widths are exact.
- letter_valid/letter_err: asserted exactly 2·TICK_DIV + 4 cycles after the final mark's falling edge at the pin (3 sync/edge + 2 units + 1 EMIT register).
- Nominal encoder timing (dot 1 unit, dash 3 units, intra-letter gap 1 unit) decodes with ≥1 half-unit margin on every threshold.
- Outputs are registered; no combinational path from morse_in.

## Structure
- Package morse_pkg: letter code constants A..H, symbol encoding (DOT=0, DASH=1), thresholds (DOT_MAX_H=3, DASH_MAX_H=8, GAP_H=4, MAX_SYM=4), state enum, and a function mapping (nsym, sym) to {hit, code}. The encoder shares this package.
- One natural sub-module: morse_tick_gen (divider with sync clear and tick output). Synchronizer and FSM stay in the top.

## Test plan
All scenarios use TICK_DIV=8 (unit = 8 cycles).
- Reset mid-letter: reset asserted during a dash → next cycle busy=0, all outputs 0. A following clean "E" still decodes to 100.
- Single letters: drive each of A–H with nominal timing → one letter_valid pulse per letter, with codes 000..111, exactly 20 cycles after the last fall.
- Boundaries: 12-cycle mark (3 half-units) → dot. 16-cycle mark → dash. 36-cycle mark → letter_err. 15-cycle gap keeps the letter open; a 16-cycle gap closes it.
- Pattern errors: five dots → letter_err, letter retains its previous value. "--" (unmapped) → letter_err. 2-cycle glitch mark → letter_err.
- Back-to-back: "A" then "G" with exactly 16-cycle gap → two valid pulses 001-free sequence 000 then 110, no err.
- Stuck high: morse_in held high for 500 cycles → busy=1, no pulses. After release and 20 cycles → letter_err.
